seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  request a division; sampled on rising clk.
REQ-004 SHALL have port: dividend  input  32  signed two's-complement numerator (register A value).
REQ-005 SHALL have port: divisor  input  32  signed two's-complement denominator (register B value).
REQ-006 SHALL have port: busy  output  1  high while an accepted division is in progress.
REQ-007 SHALL have port: done  output  1  single-cycle pulse marking a completed operation.
REQ-008 SHALL have port: div_by_zero  output  1  high when the last accepted divisor was zero.
REQ-009 SHALL have port: quotient  output  32  signed quotient, the value written to LO.
REQ-010 SHALL have port: remainder  output  32  signed remainder, the value written to HI.

Function
REQ-011 SHALL implement the states IDLE, CALC, FIX and DONE.
REQ-012 SHALL accept start only in IDLE or DONE; start SHALL be ignored in CALC and FIX.
REQ-013 At the accepting edge E0, SHALL capture dividend and divisor; later input changes have no effect on the operation.
REQ-014 At E0, SHALL clear div_by_zero.
REQ-015 At E0 with divisor != 0:
  - SHALL store the absolute values of both operands and the two sign bits.
  - SHALL load a 6-bit iteration counter with 32.
  - SHALL go to CALC.
REQ-016 At E0 with divisor == 0:
  - SHALL go directly to DONE with div_by_zero=1.
  - quotient and remainder SHALL keep their previous values.
REQ-017 CALC SHALL perform one unsigned restoring-division step per edge on a 33-bit partial remainder:
  - shift in the next dividend MSB, then subtract |divisor|.
  - if the result is non-negative, keep it and shift a 1 into the quotient; otherwise restore and shift in 0.
  - decrement the counter.
REQ-018 The edge at which the counter reaches 0 (E32) SHALL move the block to FIX.
REQ-019 At E33, FIX SHALL apply sign correction and go to DONE:
  - quotient is negated iff the operand signs differ.
  - remainder is negated iff the dividend is negative.
REQ-020 Results SHALL truncate toward zero (MIPS div semantics); the remainder sign SHALL follow the dividend; arithmetic SHALL wrap modulo 2^32.
REQ-021 0x80000000 / 0xFFFFFFFF SHALL yield quotient=0x80000000, remainder=0, with no flag.
REQ-022 done SHALL be high exactly for the cycle while the state is DONE; the next edge SHALL return to IDLE unless start is high, in which case it is a new accept (E0).
REQ-023 busy SHALL be high in CALC and FIX and low in IDLE and DONE.
REQ-024 quotient, remainder and div_by_zero SHALL hold their values until the next FIX write or accepted start (flag only).
REQ-025 Latency SHALL be fixed: done high 34 cycles after the accepting edge for a nonzero divisor, and 1 cycle after it for a zero divisor.

Reset
REQ-026 While reset=0, SHALL asynchronously force: state=IDLE, counter=0, internal registers=0, busy=0, done=0, div_by_zero=0, quotient=0, remainder=0.
REQ-027 Reset asserted mid-operation SHALL abort the division with no done pulse; the first start after release SHALL be accepted normally.
REQ-028 start sampled while reset=0 SHALL be ignored.

Verification
REQ-029 100 / 7 -> busy high E0..E33, done high the cycle after E33, quotient=14, remainder=2.
REQ-030 -7 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; 7 / -2 -> quotient=0xFFFFFFFD, remainder=1.
REQ-031 After 100/7, run 5 / 0 -> done the cycle after E0, div_by_zero=1, quotient=14 and remainder=2 unchanged, busy never high.
REQ-032 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-033 Start 100/7, pulse start with 9/3 at E5, then drop reset to 0 at E10 -> the second start is ignored; all outputs read 0 immediately; no done pulse appears; after release, 9/3 -> quotient=3, remainder=0.
REQ-034 Back-to-back: assert start with 20/6 during the done cycle of a prior op -> accepted; 34 cycles later quotient=3, remainder=2.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential signed 32-bit divider: restoring division on operand magnitudes,
// followed by a sign-fix cycle. Quotient truncates toward zero; remainder follows dividend.
module seq_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  count_q;
    logic [31:0] dvd_q;   // dividend magnitude shifts out of the top, quotient bits in at the bottom
    logic [31:0] dsr_q;
    logic [31:0] rem_q;
    logic        sign_a_q, sign_b_q;
    logic        dbz_q;
    logic [31:0] quotient_q, remainder_q;

    logic        accept;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] abs_dividend, abs_divisor;

    assign accept = start && ((state_q == StIdle) || (state_q == StDone));

    always_comb begin
        abs_dividend = dividend[31] ? (~dividend + 32'd1) : dividend;
        abs_divisor  = divisor[31]  ? (~divisor + 32'd1)  : divisor;
        shifted      = {rem_q, dvd_q[31]};
        // Remainder stays below 2^32, so a borrow always lands in bit 32.
        trial        = shifted - {1'b0, dsr_q};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = (divisor == 32'd0) ? StDone : StCalc;
            StCalc:  if (count_q == 6'd1) state_d = StFix;
            StFix:   state_d = StDone;
            StDone: begin
                if (accept) state_d = (divisor == 32'd0) ? StDone : StCalc;
                else        state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= 6'd0;
            dvd_q       <= 32'd0;
            dsr_q       <= 32'd0;
            rem_q       <= 32'd0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
        end else if (accept) begin
            dbz_q <= (divisor == 32'd0);
            if (divisor != 32'd0) begin
                dvd_q    <= abs_dividend;
                dsr_q    <= abs_divisor;
                rem_q    <= 32'd0;
                sign_a_q <= dividend[31];
                sign_b_q <= divisor[31];
                count_q  <= 6'd32;
            end
        end else if (state_q == StCalc) begin
            if (trial[32]) begin
                rem_q <= shifted[31:0];
                dvd_q <= {dvd_q[30:0], 1'b0};
            end else begin
                rem_q <= trial[31:0];
                dvd_q <= {dvd_q[30:0], 1'b1};
            end
            count_q <= count_q - 6'd1;
        end else if (state_q == StFix) begin
            quotient_q  <= (sign_a_q ^ sign_b_q) ? (~dvd_q + 32'd1) : dvd_q;
            remainder_q <= sign_a_q ? (~rem_q + 32'd1) : rem_q;
        end
    end

    assign busy        = (state_q == StCalc) || (state_q == StFix);
    assign done        = (state_q == StDone);
    assign div_by_zero = dbz_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus hand sequences for
// ignored start, mid-operation reset and back-to-back operation.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend, divisor;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    seq_divider dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is first seen (or bound expired).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int poke,
                          output int lat, output bit mid_bad);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0;
        lat      = 0;
        mid_bad  = 1'b0;
        while (!done && lat < 60) begin
            if (!busy || div_by_zero) mid_bad = 1'b1;
            if (lat == poke) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd3;
            end else begin
                start    = 1'b0;
                dividend = 32'hDEAD_BEEF;
                divisor  = 32'h0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] b, input logic [31:0] q,
                                input logic [31:0] r, input logic dbz, input int lat,
                                input bit mid_bad);
        chk({tag, " latency"}, 32'(lat), (b == 32'd0) ? 32'd0 : 32'd33);
        chk({tag, " busy_during_op"}, {31'd0, mid_bad}, 32'd0);
        chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, " quotient"}, quotient, q);
        chk({tag, " remainder"}, remainder, r);
        chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, dbz});
    endtask

    initial begin
        int  lat;
        bit  mid_bad;
        bit  saw_done;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{32'd5,          32'd0,          32'd14,         32'd2,          1'b1};
        vecs[2]  = '{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        vecs[3]  = '{32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
        vecs[4]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        vecs[5]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        vecs[6]  = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};
        vecs[7]  = '{32'hFFFF_FFFF,  32'd0,          32'd14,         32'hFFFF_FFFE,  1'b1};
        vecs[8]  = '{32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0};
        vecs[9]  = '{32'd1,          32'h8000_0000,  32'd0,          32'd1,          1'b0};
        vecs[10] = '{32'h8000_0000,  32'd7,          32'hEDB6_DB6E,  32'hFFFF_FFFE,  1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        #3 reset = 1'b0;
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset dbz", {31'd0, div_by_zero}, 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);

        // Start while held in reset must be ignored.
        @(negedge clk);
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("start_in_reset busy", {31'd0, busy}, 32'd0);
        chk("start_in_reset done", {31'd0, done}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, -1, lat, mid_bad);
            check_result($sformatf("vec%0d", i), vecs[i].b, vecs[i].q, vecs[i].r,
                         vecs[i].dbz, lat, mid_bad);
            @(negedge clk);
            chk($sformatf("vec%0d done_pulse", i), {31'd0, done}, 32'd0);
        end

        // Start during CALC is ignored; the original op finishes unchanged.
        run_op(32'd100, 32'd7, 4, lat, mid_bad);
        check_result("ignore_start", 32'd7, 32'd14, 32'd2, 1'b0, lat, mid_bad);
        @(negedge clk);
        chk("ignore_start idle_after", {30'd0, busy, done}, 32'd0);

        // Back-to-back: new start during the done cycle.
        run_op(32'd100, 32'd7, -1, lat, mid_bad);
        chk("b2b first quotient", quotient, 32'd14);
        run_op(32'd20, 32'd6, -1, lat, mid_bad);
        check_result("b2b second", 32'd6, 32'd3, 32'd2, 1'b0, lat, mid_bad);
        @(negedge clk);

        // Reset at E10 aborts 100/7; the 9/3 start at E5 is ignored.
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("abort busy_after_e5", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        reset = 1'b0;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort dbz", {31'd0, div_by_zero}, 32'd0);
        chk("abort quotient", quotient, 32'd0);
        chk("abort remainder", remainder, 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        reset = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort no_done_or_busy", {31'd0, saw_done}, 32'd0);
        run_op(32'd9, 32'd3, -1, lat, mid_bad);
        check_result("after_abort", 32'd3, 32'd3, 32'd0, 1'b0, lat, mid_bad);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
